// File: rtl/heartbeat_monitor.sv
// -----------------------------------------------------------------------------
// heartbeat_monitor
//
// Watches a heartbeat pulse train (beat_in) and checks the spacing of its
// rising edges against PERIOD +/- TOL clock cycles. After LOCK_COUNT
// consecutive in-window intervals the monitor locks. Once locked, an early
// or missing beat moves it into a sticky FAULT state. Software leaves FAULT
// by pulsing `clear`; nreset also clears it.
//
// Optional feature: define HBMON_FAULTCNT_EN to add fault_count, a saturating
// count of entries into FAULT that only nreset clears.
//
// Ports:
//   clk          clock
//   nreset       synchronous active-low reset
//   vccd1/vssd1  user area power / ground (not used by the logic)
//   beat_in      heartbeat input; each rising edge is one beat
//   clear        leaves FAULT (ignored in other states)
//   locked       high while in LOCKED
//   fault        high while in FAULT
//   miss_pulse   one-cycle pulse when a beat fails to arrive in time
//   early_pulse  one-cycle pulse when a beat arrives too soon
//   period_last  most recently measured edge-to-edge interval
//   fault_count  saturating FAULT entry count (HBMON_FAULTCNT_EN only)
//   state        IDLE=0, ACQUIRE=1, LOCKED=2, FAULT=3
// -----------------------------------------------------------------------------
module heartbeat_monitor #(
    parameter int PERIOD     = 256,
    parameter int TOL        = 4,
    parameter int LOCK_COUNT = 4,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          nreset,
    inout  wire           vccd1,
    inout  wire           vssd1,
    input  logic          beat_in,
    input  logic          clear,
    output logic          locked,
    output logic          fault,
    output logic          miss_pulse,
    output logic          early_pulse,
    output logic [CW-1:0] period_last,
`ifdef HBMON_FAULTCNT_EN
    output logic [7:0]    fault_count,
`endif
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam logic [CW-1:0] WIN_LO  = CW'(PERIOD - TOL);
    localparam logic [CW-1:0] WIN_HI  = CW'(PERIOD + TOL);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [7:0]    LOCK_C  = 8'(LOCK_COUNT);

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [CW-1:0] period_r, period_nxt_s;
    logic [CW-1:0] interval_s;
    logic [7:0]    good_r, good_nxt_s;
    logic          beat_d_r;
    logic          locked_r, fault_r, miss_r, early_r;
    logic          miss_nxt_s, early_nxt_s;
    logic          edge_s, good_edge_s, early_edge_s, late_edge_s, timeout_s;

    // Power pins are present for the macro boundary only.
    wire unused_pwr_s = vccd1 ^ vssd1;

    assign edge_s = beat_in & ~beat_d_r;

    // The interval saturates with the counter so a very long gap seen in
    // FAULT reads as the maximum value instead of wrapping to zero.
    assign interval_s   = (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);
    assign good_edge_s  = edge_s && (interval_s >= WIN_LO) && (interval_s <= WIN_HI);
    assign early_edge_s = edge_s && (interval_s < WIN_LO);
    // An edge landing exactly in the timeout cycle is already too late; it
    // is treated the same as a missing beat.
    assign late_edge_s  = edge_s && (interval_s > WIN_HI);
    assign timeout_s    = !edge_s && (cnt_r == WIN_HI);

    // Next-state, counters and registered-output values.
    always_comb begin
        state_nxt_s  = state_r;
        good_nxt_s   = good_r;
        period_nxt_s = period_r;
        miss_nxt_s   = 1'b0;
        early_nxt_s  = 1'b0;
        if (edge_s) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (cnt_r == CNT_MAX) begin
            cnt_nxt_s = cnt_r;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end

        case (state_r)
            ST_IDLE: begin
                if (edge_s) begin
                    state_nxt_s = ST_ACQUIRE;
                    good_nxt_s  = 8'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACQUIRE: begin
                if (edge_s) begin
                    period_nxt_s = interval_s;
                end else begin
                    period_nxt_s = period_r;
                end
                if (good_edge_s) begin
                    good_nxt_s = good_r + 8'd1;
                    if ((good_r + 8'd1) == LOCK_C) begin
                        state_nxt_s = ST_LOCKED;
                    end else begin
                        state_nxt_s = ST_ACQUIRE;
                    end
                end else if (early_edge_s) begin
                    early_nxt_s = 1'b1;
                    good_nxt_s  = 8'd0;
                end else if (timeout_s || late_edge_s) begin
                    miss_nxt_s  = 1'b1;
                    good_nxt_s  = 8'd0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    good_nxt_s = good_r;
                end
            end
            ST_LOCKED: begin
                if (edge_s) begin
                    period_nxt_s = interval_s;
                end else begin
                    period_nxt_s = period_r;
                end
                if (early_edge_s) begin
                    early_nxt_s = 1'b1;
                    state_nxt_s = ST_FAULT;
                end else if (timeout_s || late_edge_s) begin
                    miss_nxt_s  = 1'b1;
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            ST_FAULT: begin
                // clear takes priority; a coincident edge is discarded.
                if (clear) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CW{1'b0}};
                    good_nxt_s  = 8'd0;
                end else if (edge_s) begin
                    period_nxt_s = interval_s;
                end else begin
                    period_nxt_s = period_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                good_nxt_s  = 8'd0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            good_r   <= 8'd0;
            period_r <= {CW{1'b0}};
            beat_d_r <= 1'b0;
            locked_r <= 1'b0;
            fault_r  <= 1'b0;
            miss_r   <= 1'b0;
            early_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            good_r   <= good_nxt_s;
            period_r <= period_nxt_s;
            beat_d_r <= beat_in;
            locked_r <= (state_nxt_s == ST_LOCKED);
            fault_r  <= (state_nxt_s == ST_FAULT);
            miss_r   <= miss_nxt_s;
            early_r  <= early_nxt_s;
        end
    end

`ifdef HBMON_FAULTCNT_EN
    logic [7:0] fault_cnt_r;
    logic       fault_entry_s;

    assign fault_entry_s = (state_nxt_s == ST_FAULT) && (state_r != ST_FAULT);

    // Saturating count of FAULT entries; clear does not touch it.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            fault_cnt_r <= 8'd0;
        end else if (fault_entry_s && (fault_cnt_r != 8'hFF)) begin
            fault_cnt_r <= fault_cnt_r + 8'd1;
        end else begin
            fault_cnt_r <= fault_cnt_r;
        end
    end

    assign fault_count = fault_cnt_r;
`endif

    assign state       = state_r;
    assign locked      = locked_r;
    assign fault       = fault_r;
    assign miss_pulse  = miss_r;
    assign early_pulse = early_r;
    assign period_last = period_r;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// -----------------------------------------------------------------------------
// tb_heartbeat_monitor
//
// Drives a table of beat intervals into heartbeat_monitor (PERIOD=256, TOL=4,
// LOCK_COUNT=4, CW=16). As each beat is driven, the outputs expected at known
// future cycles are pushed to a scoreboard queue; a negedge monitor pops and
// compares the entries as their cycle comes up.
// -----------------------------------------------------------------------------
module tb_heartbeat_monitor;

    localparam int CW = 16;
`ifdef HBMON_FAULTCNT_EN
    localparam int NSIG = 7;
`else
    localparam int NSIG = 6;
`endif

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          beat_in = 1'b0;
    logic          clear = 1'b0;
    wire           vccd1 = 1'b1;
    wire           vssd1 = 1'b0;
    logic          locked, fault, miss_pulse, early_pulse;
    logic [CW-1:0] period_last;
    logic [1:0]    state;
`ifdef HBMON_FAULTCNT_EN
    logic [7:0]    fault_count;
`endif

    heartbeat_monitor #(
        .PERIOD(256), .TOL(4), .LOCK_COUNT(4), .CW(CW)
    ) dut (
        .clk(clk),
        .nreset(nreset),
        .vccd1(vccd1),
        .vssd1(vssd1),
        .beat_in(beat_in),
        .clear(clear),
        .locked(locked),
        .fault(fault),
        .miss_pulse(miss_pulse),
        .early_pulse(early_pulse),
        .period_last(period_last),
`ifdef HBMON_FAULTCNT_EN
        .fault_count(fault_count),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    // Cycle index: number of rising edges seen so far.
    int now = 0;
    always @(posedge clk) now <= now + 1;

    int checks = 0;
    int errors = 0;
    int miss_seen = 0;
    int early_seen = 0;

    typedef struct {
        int          at;
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    int gap_tbl[28] = '{256, 256, 256, 256, 252, 260, 300, 256, 256, 256,
                        256, 256, 256, 200, 256, 256, 256, 256, 251, 256,
                        256, 256, 280, 256, 256, 256, 256, 30};

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, now);
        end
    endtask

    task automatic expect_at(input int at, input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.at  = at;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] sig_value(input int sig);
        case (sig)
            0: return {30'd0, state};
            1: return {31'd0, locked};
            2: return {31'd0, fault};
            3: return {31'd0, miss_pulse};
            4: return {31'd0, early_pulse};
            5: return {16'd0, period_last};
`ifdef HBMON_FAULTCNT_EN
            6: return {24'd0, fault_count};
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Scoreboard monitor: compare every entry due this cycle.
    always @(negedge clk) begin : monitor
        int i;
        if (miss_pulse) miss_seen++;
        if (early_pulse) early_seen++;
        i = 0;
        while (i < sb_q.size()) begin
            if (sb_q[i].at == now) begin
                check_value(sb_q[i].tag, sig_value(sb_q[i].sig), sb_q[i].val);
                sb_q.delete(i);
            end else if (sb_q[i].at < now) begin
                check_value({sb_q[i].tag, "_stale"}, now, sb_q[i].at);
                sb_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a beat now (high for hi cycles) and run until the next beat is due.
    task automatic send(input int gap, input int hi, input logic clr);
        beat_in = 1'b1;
        clear   = clr;
        for (int i = 0; i < gap; i++) begin
            step();
            clear = 1'b0;
            if (i + 1 == hi) beat_in = 1'b0;
        end
    endtask

    task automatic expect_all_zero(input int at, input string tag);
        for (int s = 0; s < NSIG; s++) expect_at(at, $sformatf("%s_sig%0d", tag, s), s, 32'd0);
    endtask

    // Expected outputs for the beat with table index idx, visible from cycle e.
    task automatic push_for(input int idx, input int e);
        case (idx)
            1: begin
                expect_at(e - 1, "idle_before_e1", 0, 32'd0);
                expect_at(e, "acquire_e1", 0, 32'd1);
                expect_at(e, "period_idle_e1", 5, 32'd0);
            end
            2: begin
                expect_at(e, "period_e2", 5, 32'd256);
                expect_at(e, "acquire_e2", 0, 32'd1);
            end
            4: expect_at(e, "not_locked_e4", 1, 32'd0);
            5: begin
                expect_at(e, "locked_e5", 1, 32'd1);
                expect_at(e, "state_locked_e5", 0, 32'd2);
                expect_at(e, "no_miss_e5", 3, 32'd0);
                expect_at(e, "no_early_e5", 4, 32'd0);
            end
            6: begin
                expect_at(e, "period_252", 5, 32'd252);
                expect_at(e, "locked_252", 1, 32'd1);
            end
            7: begin
                expect_at(e, "period_260", 5, 32'd260);
                expect_at(e, "locked_260", 1, 32'd1);
                expect_at(e + 260, "miss_not_yet", 3, 32'd0);
                expect_at(e + 261, "miss_timeout", 3, 32'd1);
                expect_at(e + 261, "fault_timeout", 2, 32'd1);
                expect_at(e + 261, "unlocked_timeout", 1, 32'd0);
                expect_at(e + 261, "state_fault_timeout", 0, 32'd3);
                expect_at(e + 262, "miss_one_cycle", 3, 32'd0);
                expect_at(e + 299, "fault_sticky", 2, 32'd1);
            end
            8: begin
                expect_at(e, "period_in_fault", 5, 32'd300);
                expect_at(e, "state_fault_e8", 0, 32'd3);
                expect_at(e, "no_early_in_fault", 4, 32'd0);
            end
            9: begin
                expect_at(e, "clear_to_idle", 0, 32'd0);
                expect_at(e, "fault_cleared", 2, 32'd0);
            end
            10: expect_at(e, "reacquire", 0, 32'd1);
            13: expect_at(e, "not_relocked_e13", 1, 32'd0);
            14: expect_at(e, "relocked_e14", 1, 32'd1);
            15: begin
                expect_at(e, "period_200", 5, 32'd200);
                expect_at(e, "early_locked", 4, 32'd1);
                expect_at(e, "fault_early", 2, 32'd1);
                expect_at(e, "unlocked_early", 1, 32'd0);
                expect_at(e + 1, "early_one_cycle", 4, 32'd0);
`ifdef HBMON_FAULTCNT_EN
                expect_at(e, "fault_count_2", 6, 32'd2);
`endif
            end
            16: expect_at(e, "clear_to_idle_2", 0, 32'd0);
            17: expect_at(e, "acquire_e17", 0, 32'd1);
            20: begin
                expect_at(e, "early_acquire", 4, 32'd1);
                expect_at(e, "stay_acquire_early", 0, 32'd1);
                expect_at(e, "no_fault_acq_early", 2, 32'd0);
                expect_at(e, "period_251", 5, 32'd251);
            end
            22: expect_at(e, "good_was_reset_e22", 1, 32'd0);
            23: begin
                expect_at(e, "good_was_reset_e23", 1, 32'd0);
                expect_at(e + 261, "miss_acquire", 3, 32'd1);
                expect_at(e + 261, "acq_timeout_idle", 0, 32'd0);
                expect_at(e + 261, "acq_timeout_no_fault", 2, 32'd0);
            end
            24: expect_at(e, "acquire_held", 0, 32'd1);
            26: expect_at(e, "period_held", 5, 32'd256);
            27: expect_at(e, "not_locked_held", 1, 32'd0);
            28: begin
                expect_at(e, "locked_held", 1, 32'd1);
                expect_at(e, "state_locked_held", 0, 32'd2);
            end
            default: ;
        endcase
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", now);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int e;
        nreset  = 1'b0;
        beat_in = 1'b0;
        clear   = 1'b0;
        step();
        step();
        expect_all_zero(now + 1, "reset");
        step();
        nreset = 1'b1;
        repeat (5) step();

        for (int idx = 1; idx <= 28; idx++) begin
            e = now + 1;
            push_for(idx, e);
            send(gap_tbl[idx - 1], (idx >= 24) ? 10 : 1, (idx == 9) || (idx == 16));
        end

        // Reset for a single cycle while locked.
        expect_at(now, "locked_before_reset", 1, 32'd1);
`ifdef HBMON_FAULTCNT_EN
        expect_at(now, "fault_count_before_reset", 6, 32'd2);
`endif
        nreset = 1'b0;
        expect_all_zero(now + 1, "midreset");
        step();
        nreset = 1'b1;
        repeat (4) step();

        check_value("miss_pulse_total", miss_seen, 32'd2);
        check_value("early_pulse_total", early_seen, 32'd2);
        check_value("scoreboard_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/heartbeat_monitor.md
Name: heartbeat_monitor

Overview:
- Downstream consumer of the heartbeat pulse generator. Sits in the user area and checks the `beat_in` pulse train against an expected period and tolerance window.
- Acquires lock after a run of in-window beats. Flags early and missing beats, and latches a sticky fault.
- The fault is cleared by software through `clear` or by reset.

Parameters:
- PERIOD, 256: expected cycles between beat rising edges. Matches the default 8-bit heartbeat.
- TOL, 4: accepted deviation; the window is [PERIOD-TOL, PERIOD+TOL].
- LOCK_COUNT, 4: consecutive in-window intervals needed to lock. Legal range 1..255.
- CW, 16: interval counter and `period_last` width. Require PERIOD+TOL < 2^CW-1 and PERIOD-TOL >= 2.

Ports:
- clk  in  1  clock
- nreset  in  1  synchronous active-low reset
- vccd1  inout  1  user area 1 1.8V supply
- vssd1  inout  1  user area 1 digital ground
- beat_in  in  1  heartbeat input; a rising edge is one beat
- clear  in  1  clears FAULT; acts only in FAULT
- locked  out  1  high while state is LOCKED
- fault  out  1  sticky; high while state is FAULT
- miss_pulse  out  1  one-cycle pulse on timeout
- early_pulse  out  1  one-cycle pulse on early beat
- period_last  out  CW  last measured interval
- state  out  2  IDLE=0, ACQUIRE=1, LOCKED=2, FAULT=3

Behaviour:
- Reset: one clock, one synchronous active-low reset (nreset). On the clock edge with nreset low:
  - state=IDLE; cnt, good, period_last, beat_d = 0.
  - All outputs 0.
  - Reset works mid-operation from any state.
- Edge detect: edge = beat_in & ~beat_d, where beat_d is beat_in registered.
  - A level held high for many cycles counts as one beat.
- Interval counter cnt (CW bits):
  - On edge: period_last <= cnt+1 and cnt <= 0.
  - Otherwise cnt increments, saturating at all-ones.
  - Edges N cycles apart give period_last = N.
  - period_last updates on every edge in every state except IDLE.
- Classification of an edge:
  - interval = cnt+1.
  - good if PERIOD-TOL <= interval <= PERIOD+TOL.
  - early if interval < PERIOD-TOL.
- Timeout: no edge and cnt == PERIOD+TOL. An edge in that cycle would be too late.
- State transitions:
  - IDLE: edge -> ACQUIRE, cnt <= 0, good <= 0. No timeout check.
  - ACQUIRE, good edge: good++. If good reaches LOCK_COUNT -> LOCKED.
  - ACQUIRE, early edge: early_pulse, good <= 0, stay in ACQUIRE.
  - ACQUIRE, timeout: miss_pulse, good <= 0 -> IDLE.
  - LOCKED, good edge: stay in LOCKED.
  - LOCKED, early edge: early_pulse -> FAULT.
  - LOCKED, timeout: miss_pulse -> FAULT.
  - FAULT: edges still update period_last; no pulses. clear=1 -> IDLE, cnt <= 0, good <= 0.
  - FAULT, clear and edge in the same cycle: clear wins, next state is IDLE, the edge is discarded.
- Output timing:
  - All outputs are registered.
  - Pulses and state-derived flags appear the cycle after the triggering cycle. This is 1-cycle latency.
  - miss_pulse fires at most once per gap.
- Counter width: good counter is 8 bits and never exceeds LOCK_COUNT.

Optional Feature:
- Macro HBMON_FAULTCNT_EN.
- Defined:
  - Adds output fault_count [7:0].
  - Increments on each entry into FAULT; saturates at 255.
  - Cleared only by nreset. Not cleared by `clear`.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan (PERIOD=256, TOL=4, LOCK_COUNT=4, CW=16):
- Reset, then 1-cycle beats every 256 cycles -> state=ACQUIRE after the 1st edge; period_last=256 after the 2nd; locked=1 the cycle after the 5th edge; no pulses.
- Locked, beats stop after edge at cycle t -> miss_pulse=1 only at t+262; fault=1 and locked=0 from t+262; fault stays high.
- Locked, next edge 200 cycles later -> period_last=200; early_pulse one cycle; fault=1.
- In FAULT, beats continue; pulse clear for 1 cycle coincident with an edge -> IDLE; next edge -> ACQUIRE; relock after 4 more good intervals.
- Window boundaries:
  - In LOCKED, intervals 252 and 260 -> stay locked.
  - In ACQUIRE, interval 251 -> early_pulse, good resets, no fault.
  - In ACQUIRE, gap of 261 with no edge -> miss_pulse, state=IDLE.
- beat_in held high for 10 cycles at period 256 -> counted as single beats, lock achieved; nreset low for 1 cycle while LOCKED -> all outputs 0 the next cycle. With HBMON_FAULTCNT_EN, fault_count also returns to 0 on that reset.
